// File: rtl/mem_ctrl_nport_pkg.sv
// mem_ctrl_pkg: shared types and constants for the N-port byte-serial
// memory controller (mem_ctrl_nport) and its arbiter (mem_arb).
//   state_t   - controller FSM states
//   LEN_*     - req_len encodings (byte count minus one)
//   MAX_NPORT - largest supported port count
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  localparam int unsigned MAX_NPORT = 8;

endpackage

// File: rtl/mem_ctrl_nport_arb.sv
// mem_arb: picks one requesting port per cycle, one-hot grant.
// Build option: define MEMCTL_RR_EN for round-robin arbitration (search
// starts at the port after the last accepted one); otherwise fixed priority
// with port 0 highest and no pointer state.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer only)
//   req       - per-port request vector
//   advance   - a grant was accepted this cycle; moves the RR pointer
//   grant     - one-hot (or zero) grant, combinational from req
module mem_arb
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NPORT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic             advance,
  output logic [NPORT-1:0] grant
);

`ifdef MEMCTL_RR_EN
  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  // ptr holds the port where the next search starts
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  // Rotation expressed as a distance from ptr so every grant index is static.
  always_comb begin
    int unsigned best;
    int unsigned dist;
    grant   = '0;
    ptr_nxt = ptr;
    best    = NPORT;
    for (int unsigned i = 0; i < NPORT; i++) begin
      dist = (i + NPORT - 32'(ptr)) % NPORT;
      if (req[i] && dist < best) begin
        best     = dist;
        grant    = '0;
        grant[i] = 1'b1;
        ptr_nxt  = PW'((i + 1) % NPORT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
  end
`else
  logic unused_arb;
  assign unused_arb = &{1'b0, clk, rst, advance};

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_ctrl_nport.sv
// mem_ctrl_nport: arbitrates NPORT request ports onto one byte-serial RAM
// bus. Each request moves 1..4 bytes little-endian starting at req_addr
// (wrapping mod 2^ADDR_W); completion is a one-cycle resp_valid pulse.
// Build option: MEMCTL_RR_EN selects round-robin arbitration (see mem_arb).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-port handshake (ready one-hot, IDLE only)
//   req_wr/addr/len/wdata - per-port request fields, port i at slice i
//   resp_valid/resp_rdata - completion pulse and shared read data
//   ram_a/ram_wr/ram_dout - RAM address, write strobe, write byte
//   ram_din               - RAM read byte, valid RD_LAT cycles after ram_a
module mem_ctrl_nport
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NPORT  = 2,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        req_valid,
  output logic [NPORT-1:0]        req_ready,
  input  logic [NPORT-1:0]        req_wr,
  input  logic [NPORT*ADDR_W-1:0] req_addr,
  input  logic [NPORT*2-1:0]      req_len,
  input  logic [NPORT*32-1:0]     req_wdata,
  output logic [NPORT-1:0]        resp_valid,
  output logic [31:0]             resp_rdata,
  input  logic [7:0]              ram_din,
  output logic [7:0]              ram_dout,
  output logic [ADDR_W-1:0]       ram_a,
  output logic                    ram_wr
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t state, state_nxt;

  logic [NPORT-1:0]  grant, gnt_q;
  logic              accept;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_len;
  logic [31:0]       sel_wdata;

  logic              wr_q;
  logic [1:0]        len_q;
  logic [31:0]       wdata_q, rdata_q;
  // cycles since the first byte was addressed; runs through XFER and DRAIN
  logic [2:0]        cnt;
  logic [2:0]        cap_k;
  logic              cap_en;
  logic              last_byte;
  logic [1:0]        nxt_k;

  mem_arb #(.NPORT(NPORT)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept    = (state == IDLE) && !rst && |(req_valid & grant);
  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (grant[i]) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_len   = req_len[i*2 +: 2];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  assign last_byte = (cnt == {1'b0, len_q});
  assign nxt_k     = cnt[1:0] + 2'd1;
  // byte addressed at count c arrives on ram_din at count c+RD_LAT
  assign cap_k     = cnt - LAT;
  assign cap_en    = !wr_q && (state == XFER || state == DRAIN) &&
                     (cnt >= LAT) && (cap_k <= {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = XFER;
      XFER:    if (last_byte) state_nxt = wr_q ? RESP : DRAIN;
      DRAIN:   if (cnt == {1'b0, len_q} + LAT) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered: the byte for count k is loaded at the end
  // of count k-1 (or at accept for k=0), so ram_wr falls the cycle after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      len_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt      <= '0;
      ram_a    <= '0;
      ram_dout <= '0;
      ram_wr   <= 1'b0;
    end else begin
      ram_wr <= 1'b0;
      if (accept) begin
        gnt_q   <= grant;
        wr_q    <= sel_wr;
        len_q   <= sel_len;
        wdata_q <= sel_wdata;
        rdata_q <= '0;
        cnt     <= '0;
        ram_a   <= sel_addr;
        ram_wr  <= sel_wr;
        if (sel_wr) ram_dout <= sel_wdata[7:0];
      end else if (state == XFER || state == DRAIN) begin
        cnt <= cnt + 3'd1;
        if (state == XFER && !last_byte) begin
          ram_a  <= ram_a + ADDR_W'(1);
          ram_wr <= wr_q;
          if (wr_q) ram_dout <= wdata_q[{nxt_k, 3'b000} +: 8];
        end
      end
      if (cap_en) rdata_q[{cap_k[1:0], 3'b000} +: 8] <= ram_din;
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (state == RESP && !rst) begin
      resp_valid = gnt_q;
      resp_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_nport.sv
// tb_mem_ctrl_nport: self-checking bench for mem_ctrl_nport. A byte RAM with
// RD_LAT read latency sits on the bus; a transaction-level model predicts
// handshake, bus and response behaviour each cycle. Directed cases pin the
// model with literal values, then a randomized phase runs all ports.
// Honours MEMCTL_RR_EN for the expected arbitration order.
module tb_mem_ctrl_nport;

  localparam int NP  = 3;
  localparam int LAT = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      req_valid, req_ready, req_wr, resp_valid;
  logic [NP*32-1:0]   req_addr, req_wdata;
  logic [NP*2-1:0]    req_len;
  logic [31:0]        resp_rdata, ram_a;
  logic [7:0]         ram_din = '0;
  logic [7:0]         ram_dout;
  logic               ram_wr;

  always #5 clk = ~clk;

  mem_ctrl_nport #(.NPORT(NP), .RD_LAT(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  // ---------------- RAM environment ----------------
  logic [7:0]  ram [logic [31:0]];
  logic [31:0] hist [0:7] = '{default: '0};

  function automatic logic [7:0] init_val(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) if (ram_wr === 1'b1) ram[ram_a] = ram_dout;

  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ram_a;
    ram_din = env_rd(hist[LAT]);
  end

  // ---------------- bookkeeping ----------------
  int checks = 0, failures = 0;
  int cyc_n = 0;
  int rst_until = 3, rst_at = -1;
  bit rand_en = 0, cont_en = 0;

  bit          pend [NP];
  bit          outst [NP];
  logic        p_wr [NP];
  logic [31:0] p_addr [NP];
  logic [31:0] p_wdata [NP];
  logic [1:0]  p_len [NP];

  // transaction-level reference model
  bit          m_act = 0;
  int          m_port, m_T, m_R, m_len, m_ptr = 0;
  bit          m_wr;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [31:0] m_last_a = '0;
  logic [7:0]  ref_mem [logic [31:0]];

  // observations of the DUT for literal checks
  int          obs_T = 0, obs_lat = 0, wr_cnt = 0, resp_cnt = 0;
  logic [31:0] obs_rd = '0;
  logic [31:0] a_obs [0:3] = '{default: '0};
  int          glog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_n, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int rr_start();
`ifdef MEMCTL_RR_EN
    return m_ptr;
`else
    return 0;
`endif
  endfunction

  function automatic int pick(input logic [NP-1:0] v, input int start);
    for (int o = 0; o < NP; o++) begin
      int idx;
      idx = (start + o) % NP;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic issue(input int p, input logic wr, input logic [31:0] a,
                       input logic [1:0] len, input logic [31:0] wd);
    pend[p] = 1; p_wr[p] = wr; p_addr[p] = a; p_len[p] = len; p_wdata[p] = wd;
  endtask

  task automatic compare();
    logic [NP-1:0] e_ready, e_resp;
    logic          e_wr;
    logic [31:0]   e_a, e_rd;
    int            k, g, k2;
    e_ready = '0; e_resp = '0; e_wr = 1'b0; e_a = m_last_a; e_rd = '0; k = 0;
    if (!m_act) begin
      g = pick(req_valid, rr_start());
      if (g >= 0) e_ready[g] = 1'b1;
    end else begin
      k = cyc_n - m_T - 1;
      if (k <= m_len) begin e_a = m_addr + k; e_wr = m_wr; end
      else e_a = m_addr + m_len;
      if (cyc_n == m_R) begin e_resp[m_port] = 1'b1; e_rd = m_rd; end
    end
    chk("req_ready", req_ready, e_ready);
    chk("resp_valid", resp_valid, e_resp);
    chk("ram_a", ram_a, e_a);
    chk("ram_wr", ram_wr, e_wr);
    if (e_wr) chk("ram_dout", ram_dout, m_wdata[8*k +: 8]);
    if (|e_resp) chk("resp_rdata", resp_rdata, e_rd);
    // observations
    if (|(req_valid & req_ready)) begin
      obs_T = cyc_n; wr_cnt = 0;
      for (int i = 0; i < NP; i++) if (req_valid[i] && req_ready[i]) glog.push_back(i);
    end
    if (ram_wr === 1'b1) wr_cnt++;
    k2 = cyc_n - obs_T - 1;
    if (k2 >= 0 && k2 < 4) a_obs[k2] = ram_a;
    if (|resp_valid) begin obs_lat = cyc_n - obs_T; obs_rd = resp_rdata; resp_cnt++; end
  endtask

  task automatic update();
    int k, g;
    if (m_act && m_wr) begin
      k = cyc_n - m_T - 1;
      if (k >= 0 && k <= m_len) ref_mem[m_addr + k] = m_wdata[8*k +: 8];
    end
    if (rst) begin
      m_act = 0; m_last_a = '0; m_ptr = 0;
      for (int i = 0; i < NP; i++) begin pend[i] = 0; outst[i] = 0; end
      return;
    end
    if (m_act) begin
      if (cyc_n == m_R) begin
        m_act = 0; m_last_a = m_addr + m_len; outst[m_port] = 0;
      end
    end else begin
      g = pick(req_valid, rr_start());
      if (g >= 0) begin
        m_act = 1; m_port = g; m_wr = p_wr[g]; m_addr = p_addr[g];
        m_len = int'(p_len[g]); m_wdata = p_wdata[g]; m_T = cyc_n;
        m_R = cyc_n + m_len + 2 + (m_wr ? 0 : LAT);
        m_rd = '0;
        if (!m_wr) for (int j = 0; j <= m_len; j++) m_rd[8*j +: 8] = ref_rd(m_addr + j);
        pend[g] = 0; outst[g] = 1; m_ptr = (g + 1) % NP;
      end
    end
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rst = (cyc_n < rst_until) || (cyc_n == rst_at) ||
            (rand_en && $urandom_range(0, 399) == 0);
      if (!rst && rand_en)
        for (int i = 0; i < NP; i++)
          if (!pend[i] && !outst[i] && $urandom_range(0, 3) == 0)
            issue(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                               : 32'h100 + $urandom_range(0, 31),
                  2'($urandom_range(0, 3)), $urandom);
      if (!rst && cont_en)
        for (int i = 0; i < 2; i++)
          if (!pend[i] && !outst[i]) issue(i, 1'b0, 32'h100, 2'd0, '0);
      for (int i = 0; i < NP; i++) begin
        req_valid[i]         = pend[i] && !rst;
        req_wr[i]            = p_wr[i];
        req_addr[i*32 +: 32] = p_addr[i];
        req_len[i*2 +: 2]    = p_len[i];
        req_wdata[i*32 +: 32] = p_wdata[i];
      end
      #1;
      if (!rst) compare();
      @(posedge clk);
      update();
      #1;
      cyc_n++;
    end
  endtask

  initial begin
    int t0, rc;
    int exp_g [0:3];
    for (int i = 0; i < NP; i++) begin
      pend[i] = 0; outst[i] = 0; p_wr[i] = 0; p_addr[i] = '0; p_len[i] = '0; p_wdata[i] = '0;
    end

    run(4);
    #1;
    chk("reset ram_a", ram_a, 32'h0);
    chk("reset ram_wr", ram_wr, 1'b0);
    chk("reset ram_dout", ram_dout, 8'h00);
    chk("reset req_ready", req_ready, '0);
    chk("reset resp_valid", resp_valid, '0);
    chk("reset resp_rdata", resp_rdata, 32'h0);

    // word write on port 1
    issue(1, 1'b1, 32'h100, 2'd3, 32'hDEAD_BEEF);
    run(8);
    chk("wr latency", obs_lat, 5);
    chk("wr strobe count", wr_cnt, 4);
    chk("ram[0x100]", env_rd(32'h100), 8'hEF);
    chk("ram[0x101]", env_rd(32'h101), 8'hBE);
    chk("ram[0x102]", env_rd(32'h102), 8'hAD);
    chk("ram[0x103]", env_rd(32'h103), 8'hDE);

    // word read on port 0
    issue(0, 1'b0, 32'h100, 2'd3, '0);
    run(10);
    chk("rd word latency", obs_lat, 7);
    chk("rd word data", obs_rd, 32'hDEAD_BEEF);

    // byte read, upper bytes zero
    issue(0, 1'b0, 32'h102, 2'd0, '0);
    run(6);
    chk("rd byte latency", obs_lat, 4);
    chk("rd byte data", obs_rd, 32'h0000_00AD);

    // wrapping halfword read
    issue(1, 1'b0, 32'hFFFF_FFFF, 2'd1, '0);
    run(8);
    chk("wrap addr0", a_obs[0], 32'hFFFF_FFFF);
    chk("wrap addr1", a_obs[1], 32'h0000_0000);
    chk("wrap data", obs_rd, 32'h0000_5AA5);

    // contention between ports 0 and 1
    glog.delete();
    cont_en = 1;
    run(30);
    cont_en = 0;
    run(12);
`ifdef MEMCTL_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    chk("grant log length", glog.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant[%0d]", i), (glog.size() > i) ? glog[i] : -1, exp_g[i]);

    // reset during byte 2 of a write
    t0 = cyc_n;
    rst_at = t0 + 3;
    rc = resp_cnt;
    issue(0, 1'b1, 32'h200, 2'd3, 32'h1122_3344);
    run(4);
    #1;
    chk("abort ram_wr", ram_wr, 1'b0);
    chk("abort ram_a", ram_a, 32'h0);
    chk("abort ram_dout", ram_dout, 8'h00);
    chk("abort resp_valid", resp_valid, '0);
    chk("abort req_ready", req_ready, '0);
    chk("abort resp_rdata", resp_rdata, 32'h0);
    run(10);
    chk("abort no response", resp_cnt - rc, 0);
    issue(2, 1'b0, 32'h200, 2'd3, '0);
    run(10);
    chk("post-abort latency", obs_lat, 7);
    chk("post-abort data", obs_rd, 32'h5922_3344);

    // randomized traffic on all ports
    rand_en = 1;
    run(3000);
    rand_en = 0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_nport.md
# mem_ctrl_nport

Parametrised memory controller arbitrating NPORT request ports (instruction fetch, load/store, future DMA) onto a single byte-serial RAM bus with configurable read latency. Each port issues 1–4 byte little-endian reads or writes through a valid/ready handshake and gets a one-cycle response pulse on completion. It replaces the fixed two-port fetch/memory controller and sits between the core's front-end/LSU and the external byte-wide RAM.

## Interface
Parameters:
- NPORT, 2: number of request ports (1..8); port 0 has highest fixed priority.
- RD_LAT, 2: cycles from address driven on ram_a to its byte valid on ram_din (1..4).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NPORT  per-port request valid; held until accepted.
- req_ready  out  NPORT  per-port accept; one-hot or zero.
- req_wr  in  NPORT  1 = write, 0 = read.
- req_addr  in  NPORT*ADDR_W  byte start address, port i at slice i.
- req_len  in  NPORT*2  byte count minus 1 (0..3).
- req_wdata  in  NPORT*32  write data, byte 0 in [7:0].
- resp_valid  out  NPORT  one-cycle completion pulse to the owning port.
- resp_rdata  out  32  read data, shared; valid with resp_valid; bytes above len are zero.
- ram_din  in  8  RAM read byte.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_W  RAM address.
- ram_wr  out  1  RAM write strobe.

## Operation
- FSM states: IDLE, XFER, DRAIN, RESP.
- IDLE: arbiter picks one requesting port; req_ready[g] high combinationally for grant g only. Acceptance = req_valid[g] && req_ready[g]; addr, len, wr, wdata and port id latch; go XFER.
- XFER: one byte per cycle, byte k at ram_a = addr+k (mod 2^ADDR_W). Write: ram_wr=1, ram_dout = wdata byte k. Read: ram_wr=0. After byte len: write → RESP; read → DRAIN (or RESP if all bytes captured).
- DRAIN: ram_a holds last address, ram_wr=0; wait for remaining read bytes.
- Read capture: byte addressed in cycle c sampled from ram_din at end of cycle c+RD_LAT into rdata byte k.
- RESP: resp_valid[id]=1 for one cycle, resp_rdata = captured data (writes: 0); return to IDLE. req_ready stays low in RESP.
- ram_wr is 0 in every cycle not driving a write byte. In IDLE ram_a holds its last value.
- A port must not reassert req_valid for a new request until its resp_valid has pulsed; other ports may be accepted meanwhile only after RESP.
- Misaligned and wrapping accesses legal: address 0xFFFFFFFF len 1 touches 0xFFFFFFFF then 0x00000000.
- Fixed priority: lowest index requesting port wins.

## Timing
- Accept at cycle T. Byte k on RAM bus in cycle T+1+k.
- Write latency: resp_valid at T+len+2.
- Read latency: resp_valid at T+len+RD_LAT+2.
- Back-to-back: next accept earliest the cycle after RESP.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, ram_a=0, ram_dout=0, ram_wr=0, FSM=IDLE, RR pointer=0.
- rst mid-transfer aborts immediately; no resp_valid is issued for the aborted request; ram_wr drops the cycle after rst sampled.

## Configuration
- MEMCTL_RR_EN defined: round-robin arbitration; search starts at port after the last granted port, pointer updated on each accept.
- Undefined: fixed priority (port 0 highest); no pointer state.

## Structure
- Package mem_ctrl_pkg: FSM state enum, len encoding constants (LEN_B=0, LEN_H=1, LEN_W=3), MAX_NPORT.
- Sub-module mem_arb: NPORT request vector in, one-hot grant out, pointer register under MEMCTL_RR_EN, advance input tied to acceptance.

## Test plan
- Write port 1, addr 0x100, len 3, wdata 0xDEADBEEF → ram_wr=1 for 4 cycles, bytes EF,BE,AD,DE at 0x100..0x103; resp_valid[1] at T+5.
- Read port 0, addr 0x100, len 3, RD_LAT=2, RAM preloaded → resp_rdata=0xDEADBEEF, resp_valid[0] at T+7.
- Read byte len 0 at 0x102 → resp_rdata=0x000000AD; bytes [31:8] zero.
- Ports 0 and 1 request simultaneously, continuously → fixed priority: port 0 always granted; with MEMCTL_RR_EN: grants alternate 0,1,0,1.
- Read at 0xFFFFFFFF len 1 → ram_a sequence 0xFFFFFFFF, 0x00000000; data assembled little-endian.
- Assert rst during byte 2 of a write → no resp_valid, ram_wr=0 next cycle, all outputs at reset values; subsequent request completes normally.
